// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of imem_loader.
// master = loader side, slave = byte source / memory side.
`timescale 1ns/1ps
interface imem_loader_if #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;

  modport master (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: turns a LEN/HI/LO byte stream into instruction memory writes and holds the CPU in reset until done.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module imem_loader #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam int unsigned HI_BITS = WIDTH - 8;

  // Bits of HI above the word, and bits of LEN beyond the address range, must be zero.
  localparam logic [15:0] HI_MASK_W  = 16'h00FF << HI_BITS;
  localparam logic [15:0] LEN_MASK_W = 16'h00FF << ADDR_WIDTH;
  localparam logic [7:0]  HI_MASK    = HI_MASK_W[7:0];
  localparam logic [7:0]  LEN_MASK   = LEN_MASK_W[7:0];

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_DONE,
    ST_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , ST_CHK
`endif
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [HI_BITS-1:0]    hi_q;
  logic                  xfer;
  logic                  last;
  logic                  len_bad;
  logic                  hi_bad;
  logic                  start_ok;

  assign xfer     = bus.in_valid & bus.in_ready;
  assign last     = (cnt_q == len_q);
  assign len_bad  = |(bus.in_data & LEN_MASK);
  assign hi_bad   = |(bus.in_data & HI_MASK);
  assign start_ok = start & ((state == ST_IDLE) | (state == ST_DONE) | (state == ST_ERR));

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;

  // Running XOR over LEN and every word byte; the checksum byte itself is excluded.
  always_ff @(posedge clk) begin
    if (reset) begin
      xor_q <= 8'h00;
    end else if (start_ok) begin
      xor_q <= 8'h00;
    end else if (xfer && (state != ST_CHK)) begin
      xor_q <= xor_q ^ bus.in_data;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_LEN;
      ST_LEN:   if (xfer) state_next = len_bad ? ST_ERR : ST_HI;
      ST_HI:    if (xfer) state_next = hi_bad ? ST_ERR : ST_LO;
      ST_LO:    if (xfer) state_next = ST_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_WRITE: state_next = last ? ST_CHK : ST_HI;
      ST_CHK:   if (xfer) state_next = (bus.in_data == xor_q) ? ST_DONE : ST_ERR;
`else
      ST_WRITE: state_next = last ? ST_DONE : ST_HI;
`endif
      ST_DONE:  if (start) state_next = ST_LEN;
      ST_ERR:   if (start) state_next = ST_LEN;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register
  always_comb begin
    bus.in_ready = 1'b0;
    bus.wr_en    = 1'b0;
    cpu_hold     = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    case (state)
      ST_LEN, ST_HI, ST_LO: bus.in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK:               bus.in_ready = 1'b1;
`endif
      ST_WRITE:             bus.wr_en    = 1'b1;
      ST_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ST_ERR:               err          = 1'b1;
      default: ;
    endcase
  end

  // Word assembly and addressing; wr_addr/wr_data change only on entry to WRITE (or on a new LEN).
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q       <= '0;
      cnt_q       <= '0;
      hi_q        <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      case (state)
        ST_LEN: begin
          if (xfer && !len_bad) begin
            len_q       <= bus.in_data[ADDR_WIDTH-1:0];
            cnt_q       <= '0;
            bus.wr_addr <= '0;
          end
        end
        ST_HI: begin
          if (xfer) hi_q <= bus.in_data[HI_BITS-1:0];
        end
        ST_LO: begin
          if (xfer) begin
            bus.wr_data <= {hi_q, bus.in_data};
            bus.wr_addr <= cnt_q;
          end
        end
        ST_WRITE: begin
          if (!last) cnt_q <= cnt_q + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: driver pushes expected writes, a negedge monitor pops and compares.
// Handles both builds; checksum cases run when IMEM_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int unsigned W  = 12;
  localparam int unsigned AW = 4;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_hold;
  logic done;
  logic err;

  imem_loader_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  imem_loader #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  bit  byte_is_lo = 1'b0;
  bit  lo_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int a, input int d);
    wr_t e;
    e.addr = AW'(a);
    e.data = W'(d);
    sb.push_back(e);
  endtask

  function automatic logic [7:0] csum(input bq_t b);
    logic [7:0] x = 8'h00;
    foreach (b[i]) x = x ^ b[i];
    return x;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the byte has been taken.
  task automatic send_byte(input logic [7:0] b, input bit lo, input bit gaps);
    int n = 0;
    if (gaps) begin
      while ($urandom_range(2) == 0) begin
        bus.in_valid = 1'b0;
        byte_is_lo   = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    byte_is_lo   = lo;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n >= 50) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: byte %02h not accepted in 50 cycles, expected in_ready=1", b);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Index 0 is LEN, odd indices HI, even indices >= 2 LO.
  task automatic send_stream(input bq_t bytes, input bit gaps);
    foreach (bytes[k]) send_byte(bytes[k], (k >= 2) && (k % 2 == 0), gaps);
    bus.in_valid = 1'b0;
    byte_is_lo   = 1'b0;
  endtask

  task automatic send_image(input bq_t bytes, input bit gaps);
`ifdef IMEM_LOADER_CHECKSUM_EN
    bytes.push_back(csum(bytes));
`endif
    send_stream(bytes, gaps);
  endtask

  task automatic pulse_start(input bit chk_clear);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (chk_clear) begin
      chk("start_clr_done", 32'(done), 0);
      chk("start_clr_err", 32'(err), 0);
      chk("start_set_hold", 32'(cpu_hold), 1);
    end
  endtask

  task automatic expect_end(input string tag, input bit exp_done);
    int n = 0;
    while (!(done || err) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_err"}, 32'(err), 32'(!exp_done));
    chk({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data), 0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 1);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  // Monitor: wr_en must follow each LO transfer by one cycle and match the scoreboard head.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (lo_pend || bus.wr_en) chk("wr_en_after_lo", 32'(bus.wr_en), 32'(lo_pend));
      if (bus.wr_en) begin
        chk("in_ready_in_write", 32'(bus.in_ready), 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got write %0h@%0h, expected no write", bus.wr_data, bus.wr_addr);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
          chk("wr_data", 32'(bus.wr_data), 32'(e.data));
        end
      end
      chk("done_err_excl", 32'(done & err), 0);
      lo_pend = bus.in_valid && bus.in_ready && byte_is_lo && !reset;
    end
  end

  initial begin
    bq_t img;
    bq_t big;
    logic [7:0] hi;
    logic [7:0] lo;

    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_in_ready", 32'(bus.in_ready), 0);
    chk("idle_hold", 32'(cpu_hold), 1);

    // Basic load with continuous valid
    img = '{8'h02, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF};
    push(0, 'hABC); push(1, 'h123); push(2, 'hFFF);
    pulse_start(1'b0);
    send_image(img, 1'b0);
    expect_end("basic", 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_level", 32'(done), 1);
    chk("hold_addr", 32'(bus.wr_addr), 2);
    chk("hold_data", 32'(bus.wr_data), 'hFFF);

    // Same image with random valid gaps
    push(0, 'hABC); push(1, 'h123); push(2, 'hFFF);
    pulse_start(1'b1);
    send_image(img, 1'b1);
    expect_end("gaps", 1'b1);

    // Bad HI byte, then recovery
    pulse_start(1'b1);
    send_stream('{8'h00, 8'h1A}, 1'b0);
    expect_end("badhdr", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_level", 32'(err), 1);
    push(0, 'h123);
    pulse_start(1'b1);
    send_image('{8'h00, 8'h01, 8'h23}, 1'b0);
    expect_end("recover", 1'b1);

    // LEN beyond 2**AW-1, then a full 16-word image
    pulse_start(1'b1);
    send_stream('{8'h10}, 1'b0);
    expect_end("lenovf", 1'b0);
    big = '{8'h0F};
    for (int i = 0; i < 16; i++) begin
      hi = 8'(i % 16);
      lo = 8'(i * 37 + 5);
      big.push_back(hi);
      big.push_back(lo);
      push(i, (int'(hi) << 8) | int'(lo));
    end
    pulse_start(1'b1);
    send_image(big, 1'b0);
    expect_end("full16", 1'b1);
    chk("full16_last_addr", 32'(bus.wr_addr), 15);

    // Reset while word 1's LO byte is on the bus
    push(0, 'h123);
    pulse_start(1'b1);
    send_stream('{8'h01, 8'h01, 8'h23, 8'h04}, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h56;
    byte_is_lo   = 1'b1;
    reset        = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("midrst");
    chk("midrst_word0_written", 32'(sb.size()), 0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    byte_is_lo   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_needs_start_rdy", 32'(bus.in_ready), 0);
    chk("midrst_needs_start_done", 32'(done), 0);
    push(0, 'h456);
    pulse_start(1'b0);
    send_image('{8'h00, 8'h04, 8'h56}, 1'b0);
    expect_end("reload", 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    push(0, 'h123);
    pulse_start(1'b1);
    send_stream('{8'h00, 8'h01, 8'h23, 8'h22}, 1'b0);
    expect_end("csum_ok", 1'b1);
    push(0, 'h123);
    pulse_start(1'b1);
    send_stream('{8'h00, 8'h01, 8'h23, 8'h23}, 1'b0);
    expect_end("csum_bad", 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
